// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX scheduler: FSM state encoding,
// datapath widths and the bit-period helper used to derive cycle budgets.
package uart_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned TIMER_W = 32;
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } sched_state_e;

   function automatic int unsigned bit_period(input int unsigned clk_freq,
                                              input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] cand_s;
   logic             hit_s;

   // Scan ptr, ptr+1, ... and keep only the first hit.
   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      cand_s = '0;
      hit_s  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s = IDX_W'((32'(ptr) + 32'(k)) % NUM_REQ);
         hit_s  = ~any & req[cand_s];
         idx    = hit_s ? cand_s : idx;
         grant  = grant | (NUM_REQ'(hit_s) << cand_s);
         any    = any | hit_s;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter among NUM_REQ sources: round-robin accept,
// one frame in flight, done/timeout handling and an idle gap between frames.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned CLK_FREQ     = 50_000_000,
   parameter int unsigned BAUDRATE     = 115200,
   parameter int unsigned GAP_BITS     = 1,
   parameter int unsigned TIMEOUT_BITS = 16
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        tx_start,
   output logic [BYTE_W-1:0]           tx_byte,
   input  logic                        tx_done,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        err_timeout,
   output logic [CNT_W-1:0]            frame_cnt
);

   localparam int unsigned IDX_W       = $clog2(NUM_REQ);
   localparam logic [TIMER_W-1:0] BITPERIOD = TIMER_W'(bit_period(CLK_FREQ, BAUDRATE));
   localparam logic [TIMER_W-1:0] GAP_CYC   = TIMER_W'(GAP_BITS) * BITPERIOD;
   localparam logic [TIMER_W-1:0] TO_CYC    = TIMER_W'(TIMEOUT_BITS) * BITPERIOD;
   localparam logic [TIMER_W-1:0] GAP_LAST  = (GAP_CYC == 32'd0) ? 32'd0 : GAP_CYC - 32'd1;
   localparam logic [TIMER_W-1:0] TO_LAST   = (TO_CYC == 32'd0) ? 32'd0 : TO_CYC - 32'd1;
   // With no gap configured a finished frame returns straight to IDLE.
   localparam sched_state_e POST_FRAME = (GAP_CYC == 32'd0) ? IDLE : GAP;

   sched_state_e       state_r, state_nxt_s;
   logic [TIMER_W-1:0] timer_r, timer_nxt_s;
   logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
   logic [IDX_W-1:0]   sel_s;
   logic [NUM_REQ-1:0] grant_s;
   logic               any_s;
   logic               accept_s, done_s, err_s;
   logic               tx_start_r, busy_r;
   logic [BYTE_W-1:0]  tx_byte_r;
   logic [IDX_W-1:0]   grant_id_r;
   logic [CNT_W-1:0]   frame_cnt_r;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr_r),
      .grant (grant_s),
      .idx   (sel_s),
      .any   (any_s)
   );

   assign ptr_nxt_s = (sel_s == IDX_W'(NUM_REQ - 1)) ? '0 : sel_s + IDX_W'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, timer and event decode; tx_done beats a coincident timeout.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      accept_s    = 1'b0;
      done_s      = 1'b0;
      err_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_s && !rst) begin
               accept_s    = 1'b1;
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            timer_nxt_s = '0;
            state_nxt_s = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               done_s      = 1'b1;
               timer_nxt_s = '0;
               state_nxt_s = POST_FRAME;
            end else if (timer_r == TO_LAST) begin
               err_s       = 1'b1;
               timer_nxt_s = '0;
               state_nxt_s = POST_FRAME;
            end else begin
               timer_nxt_s = timer_r + 32'd1;
            end
         end
         GAP: begin
            if (timer_r == GAP_LAST) begin
               timer_nxt_s = '0;
               state_nxt_s = IDLE;
            end else begin
               timer_nxt_s = timer_r + 32'd1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Datapath: timer, accepted byte, pointer, counters and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_r     <= '0;
         tx_start_r  <= 1'b0;
         busy_r      <= 1'b0;
         tx_byte_r   <= 8'h00;
         grant_id_r  <= '0;
         ptr_r       <= '0;
         frame_cnt_r <= 16'h0000;
      end else begin
         timer_r    <= timer_nxt_s;
         tx_start_r <= accept_s;
         busy_r     <= (state_nxt_s != IDLE);
         if (accept_s) begin
            tx_byte_r  <= req_data[BYTE_W*sel_s +: BYTE_W];
            grant_id_r <= sel_s;
            ptr_r      <= ptr_nxt_s;
         end
         if (done_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
      end
   end

   assign req_ready   = accept_s ? grant_s : '0;
   assign err_timeout = err_s & ~rst;
   assign tx_start    = tx_start_r;
   assign tx_byte     = tx_byte_r;
   assign busy        = busy_r;
   assign grant_id    = grant_id_r;
   assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: BITPERIOD=10, GAP_CYC=10, TO_CYC=160,
// with a small TX engine model that answers tx_done a set delay after tx_start.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic        tx_done;
   logic        busy;
   logic [1:0]  grant_id;
   logic        err_timeout;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int done_delay = 100;
   int mdl_cnt;
   int cyc = 0;

   int         ts_cyc_q[$];
   logic [7:0] ts_byte_q[$];
   logic [1:0] ts_id_q[$];
   int         acc_cyc_q[$];
   int         err_cyc_q[$];

   typedef struct {
      logic [3:0] valid;
      logic [3:0] exp_ready;
      logic [1:0] exp_id;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs[9];
   vec_t one_v;

   uart_tx_scheduler #(
      .NUM_REQ(4), .CLK_FREQ(1000), .BAUDRATE(100), .GAP_BITS(1), .TIMEOUT_BITS(16)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_byte(tx_byte),
      .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
      .err_timeout(err_timeout), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // TX engine model: tx_done pulses done_delay cycles after tx_start (0 = never).
   initial begin
      tx_done = 1'b0;
      mdl_cnt = 0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (rst === 1'b1) begin
            mdl_cnt = 0;
         end else begin
            if (mdl_cnt > 0) begin
               mdl_cnt--;
               if (mdl_cnt == 0) tx_done = 1'b1;
            end
            if (tx_start === 1'b1 && done_delay > 0) mdl_cnt = done_delay;
         end
      end
   end

   // Event recorder, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (tx_start === 1'b1) begin
            ts_cyc_q.push_back(cyc);
            ts_byte_q.push_back(tx_byte);
            ts_id_q.push_back(grant_id);
         end
         if (req_ready !== 4'b0000 && req_ready !== 4'bxxxx) acc_cyc_q.push_back(cyc);
         if (err_timeout === 1'b1) err_cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         #1;
         if (busy === 1'b0) seen = 1'b1;
      end
      check({tag, "_idle_reached"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic do_frame(input vec_t v, input string tag);
      @(negedge clk);
      req_valid = v.valid;
      #1;
      check({tag, "_ready"}, {28'd0, req_ready}, {28'd0, v.exp_ready});
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd1);
      check({tag, "_grant_id"}, {30'd0, grant_id}, {30'd0, v.exp_id});
      check({tag, "_tx_byte"}, {24'd0, tx_byte}, {24'd0, v.exp_byte});
      wait_idle(400, tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
      check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
      check({tag, "_tx_byte"}, {24'd0, tx_byte}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
      check({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
      check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
   endtask

   initial begin
      logic [7:0] fair_bytes [5];
      logic [1:0] fair_ids [5];
      bit got;

      vecs[0] = '{4'b0101, 4'b0100, 2'd2, 8'hA2};
      vecs[1] = '{4'b0101, 4'b0001, 2'd0, 8'hA0};
      vecs[2] = '{4'b0101, 4'b0100, 2'd2, 8'hA2};
      vecs[3] = '{4'b1000, 4'b1000, 2'd3, 8'hA3};
      vecs[4] = '{4'b0010, 4'b0010, 2'd1, 8'hA1};
      vecs[5] = '{4'b1001, 4'b1000, 2'd3, 8'hA3};
      vecs[6] = '{4'b0110, 4'b0010, 2'd1, 8'hA1};
      vecs[7] = '{4'b0011, 4'b0001, 2'd0, 8'hA0};
      vecs[8] = '{4'b1111, 4'b0010, 2'd1, 8'hA1};
      fair_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
      fair_ids   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      rst       = 1'b1;
      req_valid = 4'b1111;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

      // Reset held with every requester valid.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check_reset_outputs("reset");
      end
      rst = 1'b0;
      #1;
      check("first_accept_ready", {28'd0, req_ready}, 32'h1);

      // Round-robin fairness with all requesters continuously valid.
      got = 1'b0;
      for (int i = 0; i < 1000 && !got; i++) begin
         @(negedge clk);
         #1;
         if (ts_cyc_q.size() >= 5) got = 1'b1;
      end
      req_valid = 4'b0000;
      check("fair_five_starts", {31'd0, got}, 32'd1);
      if (got) begin
         check("fair_accept_to_start", ts_cyc_q[0] - acc_cyc_q[0], 32'd1);
         for (int i = 0; i < 5; i++) begin
            check($sformatf("fair_byte_%0d", i), {24'd0, ts_byte_q[i]}, {24'd0, fair_bytes[i]});
            check($sformatf("fair_id_%0d", i), {30'd0, ts_id_q[i]}, {30'd0, fair_ids[i]});
         end
         for (int i = 0; i < 4; i++) begin
            check($sformatf("fair_spacing_%0d", i), ts_cyc_q[i+1] - ts_cyc_q[i], 32'd112);
         end
      end
      wait_idle(400, "fair");

      // Table of request masks, starting from pointer 1.
      for (int i = 0; i < 9; i++) begin
         do_frame(vecs[i], $sformatf("vec%0d", i));
      end
      check("frames_after_table", {16'd0, frame_cnt}, 32'd14);

      // Timeout: the engine never answers.
      ts_cyc_q.delete();
      acc_cyc_q.delete();
      err_cyc_q.delete();
      done_delay = 0;
      @(negedge clk);
      req_valid = 4'b0001;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         #1;
         if (err_cyc_q.size() >= 1) got = 1'b1;
      end
      done_delay = 100;
      check("timeout_seen", {31'd0, got}, 32'd1);
      if (got && ts_cyc_q.size() >= 1) begin
         check("timeout_latency", err_cyc_q[0] - ts_cyc_q[0], 32'd160);
      end
      check("timeout_frame_cnt", {16'd0, frame_cnt}, 32'd14);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         #1;
         if (acc_cyc_q.size() >= 2) got = 1'b1;
      end
      req_valid = 4'b0000;
      check("timeout_reaccept_seen", {31'd0, got}, 32'd1);
      if (got && err_cyc_q.size() >= 1) begin
         check("timeout_to_accept", acc_cyc_q[1] - err_cyc_q[0], 32'd11);
      end
      wait_idle(400, "after_timeout");
      check("after_timeout_frame_cnt", {16'd0, frame_cnt}, 32'd15);
      check("timeout_single_pulse", err_cyc_q.size(), 32'd1);

      // tx_done lands in the same cycle as the timeout.
      err_cyc_q.delete();
      done_delay = 160;
      one_v = '{4'b0001, 4'b0001, 2'd0, 8'hA0};
      do_frame(one_v, "coincide");
      check("coincide_no_err", err_cyc_q.size(), 32'd0);
      check("coincide_frame_cnt", {16'd0, frame_cnt}, 32'd16);

      // Reset during WAIT_DONE abandons the frame.
      done_delay = 100;
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      check("midrst_ready", {28'd0, req_ready}, 32'h2);
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      rst = 1'b0;
      ts_cyc_q.delete();
      repeat (150) @(negedge clk);
      #1;
      check("midrst_no_restart", ts_cyc_q.size(), 32'd0);
      check("midrst_cnt_after", {16'd0, frame_cnt}, 32'd0);

      // Frame counter wrap; pointer restarted at 0 after reset.
      @(negedge clk);
      force dut.frame_cnt_r = 16'hFFFF;
      #1;
      release dut.frame_cnt_r;
      #1;
      check("wrap_preload", {16'd0, frame_cnt}, 32'h0000FFFF);
      done_delay = 5;
      one_v = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
      do_frame(one_v, "wrap");
      check("wrap_frame_cnt", {16'd0, frame_cnt}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART byte transmitter among NUM_REQ byte sources, e.g. the RX echo path, a key-press message source and status sources.
- Each grant is chosen by round-robin arbitration. The block then sequences one frame at a time over a start/done handshake.
- After every frame it enforces an inter-frame idle gap, and it recovers from a transmitter that never reports done.
- It sits between the byte producers and the UART TX engine, in the same clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_FREQ, 50_000_000, main clock in Hz.
- BAUDRATE, 115200, serial bit rate.
- GAP_BITS, 1, idle line time between frames, in bit periods (0 = no gap).
- TIMEOUT_BITS, 16, bit periods to wait for tx_done before aborting.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester "byte available".
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, single-cycle accept strobe.
- tx_start  out  1  single-cycle pulse to the TX engine.
- tx_byte  out  8  byte to send; held stable from tx_start until the next accept.
- tx_done  in  1  single-cycle pulse from the TX engine at the end of the stop bit.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.
- err_timeout  out  1  single-cycle pulse when a frame is aborted.
- frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0; timeouts are not counted.

Behaviour:
- Derived constants:
  - BITPERIOD = CLK_FREQ/BAUDRATE (integer division).
  - GAP_CYC = GAP_BITS*BITPERIOD.
  - TO_CYC = TIMEOUT_BITS*BITPERIOD.
  - Internal timer is 32-bit.
- Reset (rst high at a clock edge):
  - state = IDLE; req_ready = 0; tx_start = 0; tx_byte = 0x00; busy = 0; grant_id = 0; err_timeout = 0; frame_cnt = 0; timer = 0; rr pointer = 0.
  - A reset mid-frame abandons the frame silently; tx_start is never reissued.
- State IDLE:
  - If any req_valid is high, select the first valid index scanning ptr, ptr+1, ... modulo NUM_REQ.
  - In that cycle, drive req_ready[sel] = 1 combinationally. The requester must hold data and valid until it sees ready.
  - On that edge: tx_byte <= req_data[sel]; grant_id <= sel; ptr <= (sel+1) mod NUM_REQ; go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- State ISSUE:
  - tx_start = 1 for exactly this one cycle; timer <= 0; go to WAIT_DONE.
  - Latency: accept cycle -> tx_start on the next cycle.
- State WAIT_DONE:
  - timer increments every cycle.
  - If tx_done: frame_cnt++ and go to GAP.
  - Else if timer == TO_CYC-1: err_timeout pulse and go to GAP.
  - If tx_done and the timeout coincide, tx_done wins and no error is raised.
  - tx_done in any other state is ignored.
- State GAP:
  - timer <= 0 on entry.
  - Leave for IDLE when timer == GAP_CYC-1.
  - If GAP_CYC == 0, WAIT_DONE goes directly to IDLE.
- Request handling:
  - req_ready is 0 in every state except IDLE, so at most one byte is in flight.
  - A requester dropping req_valid before it is accepted loses nothing and is simply not granted.
- Throughput:
  - Minimum spacing between accepts is 1 (ISSUE) + TX time + GAP_CYC + 1 (IDLE) cycles.

Decomposition:
- Package uart_pkg holds:
  - a function bit_period(clk_freq, baud);
  - the state enum {IDLE, ISSUE, WAIT_DONE, GAP};
  - localparam widths.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req vector, ptr;
  - outputs: one-hot grant and index;
  - purely combinational, with the pointer register kept in the scheduler.
- The scheduler holds the FSM, timer, latches and counters.

Test Plan (CLK_FREQ=1000, BAUDRATE=100 -> BITPERIOD=10, GAP_CYC=10, TO_CYC=160; behavioural TX model returns tx_done 100 cycles after tx_start):
- Reset check: assert rst for 3 cycles, req_valid=4'b1111 -> all outputs at reset values during reset; first accept after release is requester 0, and tx_start follows it by exactly 1 cycle.
- Round-robin fairness: all four requesters continuously valid with bytes 0xA0..0xA3 -> tx_byte sequence A0,A1,A2,A3,A0; grant_id 0,1,2,3,0; consecutive tx_start pulses 112 cycles apart (1+100+10+1).
- Pointer skip: only req_valid[2] and req_valid[0] high, previous grant 2 -> next grant is 0, then 2.
- Timeout: TX model never pulses tx_done -> err_timeout pulses 160 cycles after tx_start, frame_cnt unchanged, next accept 11 cycles after the pulse.
- Simultaneous done and timeout: tx_done arrives in the cycle with timer==159 -> no err_timeout, frame_cnt increments by 1.
- Reset mid-operation and counter wrap: assert rst during WAIT_DONE -> busy=0 next cycle and no tx_start for that byte; preload 65535 frames (or force frame_cnt to 0xFFFF) then complete one frame -> frame_cnt = 0.
